// File: rtl/mem_boot_ctrl_pkg.sv
// Shared types for the boot-load controller: FSM state encoding and run-timer width.
package mem_boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int RUN_CNT_W = 16;

endpackage

// File: rtl/mem_boot_ctrl_run_timer.sv
// Loadable down counter with zero flag; stops at zero, load has priority over decrement.
module run_timer
  import mem_boot_pkg::*;
#(
  parameter int W = RUN_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_boot_ctrl.sv
// Boot-load controller: streams an image into a shared RAM, runs the core for RUN_CYCLES, then allows readback.
// Optional MEM_BOOT_CTRL_ALIGN_CHECK_EN: misaligned load beats are dropped and flag a sticky err.
//
// state | meaning
// IDLE  | core held in reset, readback port owns the RAM
// LOAD  | load beats written to RAM, core held in reset
// RUN   | core released and owns the RAM for RUN_CYCLES cycles
// DONE  | core held in reset, readback port owns the RAM, done=1
module mem_boot_ctrl
  import mem_boot_pkg::*;
#(
  parameter int RUN_CYCLES = 30,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          core_reset,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] core_rdata,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err
);

  localparam logic [RUN_CNT_W-1:0] LP_RUN_LOAD = RUN_CNT_W'(RUN_CYCLES - 1);

  state_e        r_state;
  state_e        w_next;
  logic          w_beat;
  logic          w_align_ok;
  logic          w_start_acc;
  logic          w_timer_zero;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;

  // ld_ready is gated by reset_n, so no handshake (and no write) completes in a reset cycle
  assign w_beat      = (r_state == ST_LOAD) && ld_valid && reset_n;
  assign w_start_acc = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

`ifdef MEM_BOOT_CTRL_ALIGN_CHECK_EN
  logic r_err;

  assign w_align_ok = (ld_addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_beat && !w_align_ok) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_align_ok = 1'b1;
  assign err        = 1'b0;
`endif

  run_timer #(.W(RUN_CNT_W)) u_run_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_beat && ld_last),
    .i_load_val (LP_RUN_LOAD),
    .i_dec      (r_state == ST_RUN),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    ld_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = rd_addr;
    ram_wdata  = '0;
    core_reset = 1'b1;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready  = reset_n;
        ram_addr  = ld_addr;
        ram_wdata = ld_data;
        ram_we    = w_beat && w_align_ok;
        if (w_beat && ld_last) w_next = ST_RUN;
      end
      ST_RUN: begin
        core_reset = 1'b0;
        ram_addr   = core_addr;
        ram_wdata  = core_wdata;
        ram_we     = core_we && reset_n;
        if (w_timer_zero) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_start_acc) w_next = ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Readback response registered one cycle after the request edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req && ((r_state == ST_IDLE) || (r_state == ST_DONE));
      r_rd_data  <= ram_rdata;
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign core_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Self-checking bench for mem_boot_ctrl: per-cycle comparison against a session-level model plus directed literal checks.
module tb_mem_boot_ctrl;

  localparam int RC = 30;
`ifdef MEM_BOOT_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0, start = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        ld_ready, core_reset, ram_we, rd_valid, done, err;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, core_rdata, rd_data;

  logic        ld_ready1, core_reset1, ram_we1, rd_valid1, done1, err1;
  logic [31:0] ram_addr1, ram_wdata1, core_rdata1, rd_data1;
  logic [31:0] zero32 = '0;

  logic [31:0] ram [0:255] = '{default: 32'h0};
  logic [31:0] mm  [0:255] = '{default: 32'h0};

  assign ram_rdata = ram[ram_addr[7:0]];
  always @(posedge clk) if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;

  mem_boot_ctrl #(.RUN_CYCLES(RC), .AW(32), .DW(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .core_reset(core_reset),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .core_rdata(core_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err));

  mem_boot_ctrl #(.RUN_CYCLES(1), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready1),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .core_reset(core_reset1),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata), .ram_we(ram_we1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(zero32), .core_rdata(core_rdata1),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .done(done1), .err(err1));

  int checks = 0, errors = 0;
  int n_we = 0, n_run = 0, n_run1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Session model: 0 idle, 1 loading, 2 core running (m_left cycles remain), 3 finished
  int          m_mode = 0, m_left = 0;
  bit          m_rv = 1'b0, m_err = 1'b0, m_live = 1'b0;
  logic [31:0] m_rd = '0;

  function automatic bit misaligned(input logic [31:0] a);
    return ALIGN && (a[1:0] != 2'b00);
  endfunction

  always @(posedge clk) begin
    m_live = 1'b1;
    if (!reset_n) begin
      m_mode = 0; m_left = 0; m_rv = 1'b0; m_err = 1'b0;
    end else begin
      m_rv = rd_req && (m_mode == 0 || m_mode == 3);
      m_rd = mm[rd_addr[7:0]];
      case (m_mode)
        0, 3: if (start) begin m_mode = 1; m_err = 1'b0; end
        1: if (ld_valid) begin
          if (misaligned(ld_addr)) m_err = 1'b1;
          else mm[ld_addr[7:0]] = ld_data;
          if (ld_last) begin m_mode = 2; m_left = RC; end
        end
        2: begin
          if (core_we) mm[core_addr[7:0]] = core_wdata;
          m_left--;
          if (m_left == 0) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic        e_we;
      logic [31:0] e_addr;
      e_addr = (m_mode == 1) ? ld_addr : (m_mode == 2) ? core_addr : rd_addr;
      e_we = reset_n && ((m_mode == 1 && ld_valid && !misaligned(ld_addr)) || (m_mode == 2 && core_we));
      chk("core_reset", core_reset, m_mode != 2);
      chk("ld_ready", ld_ready, reset_n && m_mode == 1);
      chk("done", done, m_mode == 3);
      chk("err", err, m_err);
      chk("rd_valid", rd_valid, m_rv);
      if (m_rv) chk("rd_data", rd_data, m_rd);
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      if (e_we) chk("ram_wdata", ram_wdata, (m_mode == 1) ? ld_data : core_wdata);
      chk("core_rdata", core_rdata, ram[e_addr[7:0]]);
      if (ram_we) n_we++;
      if (!core_reset && reset_n) n_run++;
      if (!core_reset1 && reset_n) n_run1++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) tick();
    chk("done_within_budget", done, 1'b1);
  endtask

  task automatic readback(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
    chk({nm, "_valid"}, rd_valid, 1'b1);
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    reset_n = 1'b1;
    tick();

    // Basic two-beat session, full run, readback
    n_we = 0; n_run = 0; n_run1 = 0;
    do_start();
    beat(32'h60, 32'h7, 1'b0);
    beat(32'h64, 32'h19, 1'b1);
    wait_done();
    chk("t1_write_pulses", n_we, 2);
    chk("t1_run_cycles", n_run, 30);
    chk("t1_run_cycles_rc1", n_run1, 1);
    readback("t1_rb_60", 32'h60, 32'h7);
    readback("t1_rb_64", 32'h64, 32'h19);

    // Gapped beats; RUN only after last
    n_we = 0;
    do_start();
    beat(32'h20, 32'hA1, 1'b0);
    repeat (3) tick();
    chk("t2_gap_writes", n_we, 1);
    chk("t2_gap_core_reset", core_reset, 1'b1);
    beat(32'h24, 32'hB2, 1'b0);
    repeat (3) tick();
    chk("t2_gap_core_reset2", core_reset, 1'b1);
    beat(32'h28, 32'hC3, 1'b1);
    chk("t2_run_entered", core_reset, 1'b0);
    wait_done();
    chk("t2_write_pulses", n_we, 3);
    readback("t2_rb_24", 32'h24, 32'hB2);
    readback("t2_rb_28", 32'h28, 32'hC3);

    // Core writes land only in RUN
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    core_we = 1'b1; core_addr = 32'h14; core_wdata = 32'h68;
    tick(); tick();
    readback("t3_rb_idle_14", 32'h14, 32'h0);
    do_start();
    beat(32'h30, 32'h1, 1'b1);
    wait_done();
    core_we = 1'b0;
    readback("t3_rb_run_14", 32'h14, 32'h68);

    // Reset during RUN cycle 10
    do_start();
    beat(32'h40, 32'h5, 1'b1);
    repeat (10) tick();
    chk("t4_in_run", core_reset, 1'b0);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("t4_core_reset", core_reset, 1'b1);
    chk("t4_done", done, 1'b0);
    repeat (40) tick();
    chk("t4_done_later", done, 1'b0);

    // Reset mid-LOAD with a beat presented: nothing written
    do_start();
    ld_valid = 1'b1; ld_addr = 32'h50; ld_data = 32'h99;
    reset_n = 1'b0; tick();
    ld_valid = 1'b0; reset_n = 1'b1;
    readback("t5_rb_50", 32'h50, 32'h0);

    // Misaligned beat
    do_start();
    beat(32'h2, 32'hEE, 1'b1);
    chk("t6_err", err, ALIGN);
    wait_done();
    chk("t6_err_sticky", err, ALIGN);
    readback("t6_rb_02", 32'h2, ALIGN ? 32'h0 : 32'hEE);
    do_start();
    chk("t6_err_cleared", err, 1'b0);
    beat(32'h8, 32'h1, 1'b1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_boot_ctrl.md
MEM_BOOT_CTRL -- requirements
Module: mem_boot_ctrl

Interface
REQ-001 Parameter RUN_CYCLES, default 30: core run time in clk cycles; legal range 1..65535.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  begin load session; level-sampled.
REQ-007 ld_valid  in  1  load beat valid.
REQ-008 ld_ready  out  1  load beat accepted when ld_valid && ld_ready.
REQ-009 ld_addr  in  AW  load beat target address.
REQ-010 ld_data  in  DW  load beat data.
REQ-011 ld_last  in  1  final beat of session.
REQ-012 core_reset  out  1  active-high reset to the core.
REQ-013 core_we, core_addr[AW], core_wdata[DW]  in  core data-memory request.
REQ-014 ram_we, ram_addr[AW], ram_wdata[DW]  out  shared RAM port.
REQ-015 ram_rdata  in  DW  RAM read data, combinational from ram_addr.
REQ-016 core_rdata  out  DW  ram_rdata forwarded to the core.
REQ-017 rd_req  in  1, rd_addr  in  AW: readback request.
REQ-018 rd_valid  out  1, rd_data  out  DW: readback response.
REQ-019 done  out  1, err  out  1: session complete, sticky load error.

Function
REQ-020 FSM states IDLE, LOAD, RUN, DONE.
REQ-021 IDLE: start=1 -> LOAD; else stay.
REQ-022 LOAD: ld_ready=1; accepted beat drives ram_we=1, ram_addr=ld_addr, ram_wdata=ld_data in the same cycle; accepted beat with ld_last=1 -> RUN next cycle.
REQ-023 LOAD with ld_valid=0: ram_we=0, state held indefinitely.
REQ-024 RUN: core_reset=0; ram_we/ram_addr/ram_wdata = core_we/core_addr/core_wdata; run timer loaded with RUN_CYCLES-1 on entry, decrements each RUN cycle; RUN lasts exactly RUN_CYCLES cycles, then -> DONE.
REQ-025 Outside RUN: core_reset=1 and core_we ignored (never reaches ram_we).
REQ-026 DONE: done=1; start=1 -> LOAD and done clears that edge.
REQ-027 start in LOAD or RUN ignored.
REQ-028 Readback legal in IDLE and DONE only: ram_addr=rd_addr, ram_we=0; rd_req=1 at edge N gives rd_valid=1, rd_data=ram_rdata(rd_addr sampled at N) during cycle N+1; back-to-back rd_req gives one response per cycle.
REQ-029 rd_req in LOAD or RUN produces no rd_valid.
REQ-030 core_rdata = ram_rdata in all states.
REQ-031 IDLE/DONE with rd_req=0: ram_addr=rd_addr, ram_we=0.

Reset
REQ-032 reset_n=0 at an edge -> IDLE; core_reset=1, ld_ready=0, ram_we=0, rd_valid=0, done=0, err=0, timer=0.
REQ-033 Reset mid-LOAD or mid-RUN aborts the session; no partial beat is written in the reset cycle.

Configuration
REQ-034 Macro MEM_BOOT_CTRL_ALIGN_CHECK_EN defined: a LOAD beat with ld_addr[1:0]!=0 is accepted (handshake completes, ld_last still honoured) but not written; err sets and stays set until reset or next start.
REQ-035 Macro undefined: no check, every beat written, err tied 0.

Structure
REQ-036 Package mem_boot_pkg holds the state enum and the RUN_CYCLES width constant.
REQ-037 One sub-module run_timer: loadable down counter with zero flag, instantiated once.

Verification
REQ-038 Reset, start, beats (0x60,7),(0x64,0x19 last) -> two ram_we pulses, RUN for 30 cycles, done=1; readback 0x60 -> 7, 0x64 -> 0x19.
REQ-039 ld_valid gaps of 3 cycles between beats -> no writes during gaps, RUN entered only after ld_last beat.
REQ-040 core_we=1, addr 0x14, data 0x68 in IDLE and in RUN -> only the RUN write lands; readback 0x14 -> 0x68.
REQ-041 reset_n=0 at RUN cycle 10 -> IDLE next cycle, core_reset=1, done never asserts.
REQ-042 RUN_CYCLES=1 -> exactly one cycle with core_reset=0.
REQ-043 With MEM_BOOT_CTRL_ALIGN_CHECK_EN, beat addr 0x2 -> no write, err=1; without macro -> write, err=0.
